simple_uart: RTL and testbench
==============================

Name: simple_uart

Overview:
Memory-mapped 8N1 UART with a runtime-programmable baud divider, one-byte receive buffer and one-byte transmit shifter. Sits on a simple register strobe bus (divider register plus data register) and drives and receives the board serial pins. Used by processor and test tops to emit ASCII results.

Parameters:
DEFAULT_DIV, 1, divider loaded at reset (clock cycles per bit; effective minimum 2).

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
ser_rx  in  1  serial input, idle high, asynchronous to clk
ser_tx  out  1  serial output, idle high
reg_div_we  in  4  byte-lane write enables for the divider register
reg_div_di  in  32  divider write data
reg_div_do  out  32  current divider value
reg_dat_we  in  1  transmit-byte write strobe
reg_dat_re  in  1  receive-byte read/acknowledge strobe
reg_dat_di  in  32  transmit data; only bits [7:0] are used
reg_dat_do  out  32  receive data
reg_dat_wait  out  1  write stall

Behaviour:
- Reset (resetn low, asynchronous):
  - cfg_div = DEFAULT_DIV, ser_tx = 1.
  - Receive buffer invalid, RX state idle.
  - TX idle with the dummy flag set.
- Effective bit period P = max(cfg_div, 2) cycles.
- Divider register:
  - Each asserted lane i loads reg_div_di[8i+7:8i] the next cycle.
  - reg_div_do = cfg_div, combinational.
- Any divider write aborts an in-flight TX frame: ser_tx is forced to 1 next cycle and the dummy flag is set.
- Transmit:
  - While the dummy flag is set and TX is idle, send 15 idle (high) bit periods, then clear the flag.
  - reg_dat_wait = reg_dat_we AND (TX busy OR dummy flag set), combinational.
  - A write is accepted in the cycle reg_dat_we=1 and reg_dat_wait=0.
  - Frame: start 0, data bits LSB first, stop 1. Each bit lasts exactly P cycles.
  - ser_tx drives the start bit on the cycle after acceptance.
  - TX is busy from acceptance until the stop bit completes (10·P cycles); the next write may be accepted on the following cycle.
- Receive:
  - ser_rx passes through a 2-FF synchronizer.
  - Idle: a sampled 0 starts a frame. Wait P/2 (floor) cycles and recheck. If 1, it was a glitch: return to idle.
  - Then sample 8 data bits (LSB first) and the stop bit, each P cycles apart.
  - Stop bit 1: the byte goes to the buffer and valid is set.
  - Stop bit 0: framing error, byte discarded, buffer unchanged.
  - Overrun: a new byte overwrites the buffer; valid stays 1.
- reg_dat_do = valid ? {24'h0, buf} : 32'hFFFF_FFFF, combinational.
- reg_dat_re clears valid next cycle. If a new byte completes in the same cycle, the new byte is stored and valid remains 1.
- Changing the divider mid-RX-frame takes effect immediately and is not protected.

Optional Feature:
SIMPLE_UART_RX_EN
- Defined: receiver, synchronizer and buffer are present as above.
- Undefined: receiver logic is removed, ser_rx is ignored, reg_dat_do is constant 32'hFFFF_FFFF, and reg_dat_re has no effect.
- TX and the divider register are identical in both cases.

Decomposition:
- Package simple_uart_pkg: RX state enum (IDLE, START, DATA, STOP), frame length constants (DATA_BITS=8, FRAME_BITS=10, DUMMY_BITS=15), MIN_DIV=2.
- One natural sub-module: simple_uart_rx (synchronizer, RX FSM, buffer). It is instantiated only under SIMPLE_UART_RX_EN.
- TX and the divider stay in the top.

Test Plan:
- Reset then idle → ser_tx=1, reg_div_do=DEFAULT_DIV, reg_dat_do=FFFF_FFFF. A write during the 15-bit dummy period sees reg_dat_wait=1 until the dummy completes.
- Divider write reg_div_we=4'b1111 with di=4, then write 0x55 → ser_tx shows 0,1,0,1,0,1,0,1,0,1 with each bit exactly 4 cycles, then reg_dat_wait=0.
- Byte-lane write: div=0x00000100, then reg_div_we=4'b0001 with di=0x000000AA → reg_div_do=0x000001AA.
- RX with div=8: drive frame for 0xA3 → valid is set, reg_dat_do=0x000000A3. Pulse reg_dat_re → reg_dat_do=FFFF_FFFF.
- RX a 2-cycle low glitch (div=8) → no byte. Then a frame 0x3C with stop bit 0 → buffer unchanged, valid=0.
- Assert resetn low mid-TX frame → ser_tx=1 immediately, and reg_div_do returns to DEFAULT_DIV.

Source files
------------

// File: rtl/simple_uart_pkg.sv
// rtl/simple_uart_pkg.sv - shared types and frame constants for the 8N1 UART
package simple_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 10;
   localparam int DUMMY_BITS = 15;
   localparam int MIN_DIV    = 2;

   // Bit period in clock cycles; dividers below MIN_DIV are clamped.
   function automatic logic [31:0] eff_div(input logic [31:0] div);
      return (div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : div;
   endfunction

endpackage

// File: rtl/simple_uart_rx.sv
// rtl/simple_uart_rx.sv - receive path: 2-FF synchronizer, frame FSM, one-byte buffer
module simple_uart_rx
   import simple_uart_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        ser_rx_i,
   input  logic [31:0] period_i,
   input  logic        rd_ack_i,
   output logic [7:0]  data_o,
   output logic        valid_o
);

   logic        rx_meta_q, rx_sync_q;
   rx_state_e   state_q;
   logic [31:0] divcnt_q;
   logic [2:0]  bitcnt_q;
   logic [7:0]  shift_q, buf_q;
   logic        valid_q;
   logic [31:0] half;

   assign half    = period_i >> 1;
   assign data_o  = buf_q;
   assign valid_o = valid_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         state_q   <= IDLE;
         divcnt_q  <= '0;
         bitcnt_q  <= '0;
         shift_q   <= '0;
         buf_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         rx_meta_q <= ser_rx_i;
         rx_sync_q <= rx_meta_q;
         // A byte completing in the same cycle as an acknowledge wins below.
         if (rd_ack_i) valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rx_sync_q) begin
                  state_q  <= START;
                  divcnt_q <= '0;
               end
            end
            START: begin
               if (divcnt_q >= half - 1) begin
                  state_q  <= rx_sync_q ? IDLE : DATA;
                  divcnt_q <= '0;
                  bitcnt_q <= '0;
               end else begin
                  divcnt_q <= divcnt_q + 1;
               end
            end
            DATA: begin
               if (divcnt_q >= period_i - 1) begin
                  shift_q  <= {rx_sync_q, shift_q[7:1]};
                  divcnt_q <= '0;
                  bitcnt_q <= bitcnt_q + 3'd1;
                  if (bitcnt_q == 3'(DATA_BITS - 1)) state_q <= STOP;
               end else begin
                  divcnt_q <= divcnt_q + 1;
               end
            end
            STOP: begin
               if (divcnt_q >= period_i - 1) begin
                  if (rx_sync_q) begin
                     buf_q   <= shift_q;
                     valid_q <= 1'b1;
                  end
                  state_q  <= IDLE;
                  divcnt_q <= '0;
               end else begin
                  divcnt_q <= divcnt_q + 1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/simple_uart.sv
// rtl/simple_uart.sv - memory-mapped 8N1 UART top (TX, divider); receiver present only with SIMPLE_UART_RX_EN
module simple_uart
   import simple_uart_pkg::*;
#(
   parameter logic [31:0] DEFAULT_DIV = 32'd1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ser_rx,
   output logic        ser_tx,
   input  logic [3:0]  reg_div_we,
   input  logic [31:0] reg_div_di,
   output logic [31:0] reg_div_do,
   input  logic        reg_dat_we,
   input  logic        reg_dat_re,
   input  logic [31:0] reg_dat_di,
   output logic [31:0] reg_dat_do,
   output logic        reg_dat_wait
);

   logic [31:0] cfg_div_q, cfg_div_d;
   logic [9:0]  pattern_q, pattern_d;
   logic [3:0]  bitcnt_q, bitcnt_d;
   logic [31:0] divcnt_q, divcnt_d;
   logic        dummy_q, dummy_d;
   logic [31:0] period;
   logic        tx_busy, dat_accept;

   assign period       = eff_div(cfg_div_q);
   assign tx_busy      = (bitcnt_q != 4'd0);
   assign reg_div_do   = cfg_div_q;
   assign reg_dat_wait = reg_dat_we && (tx_busy || dummy_q);
   assign dat_accept   = reg_dat_we && !reg_dat_wait;
   assign ser_tx       = pattern_q[0];

   always_comb begin
      cfg_div_d = cfg_div_q;
      pattern_d = pattern_q;
      bitcnt_d  = bitcnt_q;
      divcnt_d  = divcnt_q;
      dummy_d   = dummy_q;
      for (int i = 0; i < 4; i++) begin
         if (reg_div_we[i]) cfg_div_d[8*i +: 8] = reg_div_di[8*i +: 8];
      end
      // A divider change abandons the current frame and re-idles the line.
      if (|reg_div_we) begin
         pattern_d = '1;
         bitcnt_d  = '0;
         divcnt_d  = '0;
         dummy_d   = 1'b1;
      end else if (dummy_q && !tx_busy) begin
         pattern_d = '1;
         bitcnt_d  = 4'(DUMMY_BITS);
         divcnt_d  = '0;
         dummy_d   = 1'b0;
      end else if (dat_accept) begin
         pattern_d = {1'b1, reg_dat_di[7:0], 1'b0};
         bitcnt_d  = 4'(FRAME_BITS);
         divcnt_d  = '0;
      end else if (tx_busy) begin
         if (divcnt_q >= period - 1) begin
            pattern_d = {1'b1, pattern_q[9:1]};
            bitcnt_d  = bitcnt_q - 4'd1;
            divcnt_d  = '0;
         end else begin
            divcnt_d  = divcnt_q + 1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cfg_div_q <= DEFAULT_DIV;
         pattern_q <= '1;
         bitcnt_q  <= '0;
         divcnt_q  <= '0;
         dummy_q   <= 1'b1;
      end else begin
         cfg_div_q <= cfg_div_d;
         pattern_q <= pattern_d;
         bitcnt_q  <= bitcnt_d;
         divcnt_q  <= divcnt_d;
         dummy_q   <= dummy_d;
      end
   end

`ifdef SIMPLE_UART_RX_EN
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       unused_sig;

   simple_uart_rx u_rx (
      .clk      (clk),
      .resetn   (resetn),
      .ser_rx_i (ser_rx),
      .period_i (period),
      .rd_ack_i (reg_dat_re),
      .data_o   (rx_data),
      .valid_o  (rx_valid)
   );

   assign reg_dat_do = rx_valid ? {24'h0, rx_data} : 32'hFFFF_FFFF;
   assign unused_sig = ^reg_dat_di[31:8];
`else
   logic unused_sig;

   assign reg_dat_do = 32'hFFFF_FFFF;
   assign unused_sig = ^{reg_dat_di[31:8], ser_rx, reg_dat_re};
`endif

endmodule

// File: tb/tb_simple_uart.sv
// tb/tb_simple_uart.sv - randomized self-checking bench for simple_uart against a frame-level model
module tb_simple_uart;
   import simple_uart_pkg::*;

   localparam logic [31:0] DEF_DIV = 32'd1;
`ifdef SIMPLE_UART_RX_EN
   localparam bit RX_EN = 1'b1;
`else
   localparam bit RX_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        ser_rx = 1'b1;
   logic        ser_tx;
   logic [3:0]  reg_div_we = '0;
   logic [31:0] reg_div_di = '0;
   logic [31:0] reg_div_do;
   logic        reg_dat_we = 1'b0;
   logic        reg_dat_re = 1'b0;
   logic [31:0] reg_dat_di = '0;
   logic [31:0] reg_dat_do;
   logic        reg_dat_wait;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] model_div = DEF_DIV;
   logic        model_valid = 1'b0;
   logic [7:0]  model_buf = '0;

   simple_uart #(.DEFAULT_DIV(DEF_DIV)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .ser_rx       (ser_rx),
      .ser_tx       (ser_tx),
      .reg_div_we   (reg_div_we),
      .reg_div_di   (reg_div_di),
      .reg_div_do   (reg_div_do),
      .reg_dat_we   (reg_dat_we),
      .reg_dat_re   (reg_dat_re),
      .reg_dat_di   (reg_dat_di),
      .reg_dat_do   (reg_dat_do),
      .reg_dat_wait (reg_dat_wait)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic int bit_period();
      return (model_div < 32'(MIN_DIV)) ? MIN_DIV : int'(model_div);
   endfunction

   function automatic logic [31:0] exp_dat_do();
      return (RX_EN && model_valid) ? {24'h0, model_buf} : 32'hFFFF_FFFF;
   endfunction

   task automatic div_write(input logic [3:0] we, input logic [31:0] di);
      reg_div_we = we;
      reg_div_di = di;
      @(negedge clk);
      reg_div_we = '0;
      for (int i = 0; i < 4; i++) if (we[i]) model_div[8*i +: 8] = di[8*i +: 8];
   endtask

   // Holds the write until accepted; returns the number of stalled cycles.
   task automatic tx_write(input logic [7:0] data, output int waits);
      int guard = 0;
      waits = 0;
      reg_dat_we = 1'b1;
      reg_dat_di = {24'($urandom), data};
      #1;
      while (reg_dat_wait && guard < 5000) begin
         @(negedge clk);
         #1;
         waits++;
         guard++;
      end
      if (guard >= 5000) check("tx_accept_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1 reg_dat_we = 1'b0;
   endtask

   task automatic check_frame(input logic [7:0] data, input string tag);
      logic [9:0] bits;
      int p;
      bits = {1'b1, data, 1'b0};
      p = bit_period();
      for (int b = 0; b < FRAME_BITS; b++) begin
         int ones = 0;
         int obs;
         for (int k = 0; k < p; k++) begin
            @(negedge clk);
            ones += int'(ser_tx);
         end
         obs = (ones == p) ? 1 : (ones == 0) ? 0 : 2;
         check($sformatf("%s_bit%0d", tag, b), 32'(obs), 32'(bits[b]));
      end
   endtask

   task automatic rx_send(input logic [7:0] data, input logic stop_bit);
      logic [9:0] bits;
      int p;
      bits = {stop_bit, data, 1'b0};
      p = bit_period();
      for (int b = 0; b < FRAME_BITS; b++) begin
         ser_rx = bits[b];
         repeat (p) @(negedge clk);
      end
      ser_rx = 1'b1;
      repeat (2 * p) @(negedge clk);
      if (stop_bit) begin
         model_buf   = data;
         model_valid = 1'b1;
      end
   endtask

   task automatic rx_ack();
      reg_dat_re = 1'b1;
      @(negedge clk);
      reg_dat_re = 1'b0;
      model_valid = 1'b0;
      check("rx_after_ack", reg_dat_do, exp_dat_do());
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      logic [7:0] b0, b1;

      repeat (3) @(negedge clk);
      check("reset_ser_tx", 32'(ser_tx), 32'd1);
      check("reset_div", reg_div_do, DEF_DIV);
      check("reset_dat_do", reg_dat_do, 32'hFFFF_FFFF);

      resetn = 1'b1;
      tx_write(8'hA5, w);
      check("dummy_wait_reset", 32'(w), 32'(DUMMY_BITS * bit_period() + 1));
      check_frame(8'hA5, "frame_min_div");

      div_write(4'b1111, 32'd4);
      check("div_full_write", reg_div_do, 32'd4);
      tx_write(8'h55, w);
      check("dummy_wait_div4", 32'(w), 32'(DUMMY_BITS * 4 + 1));
      check_frame(8'h55, "frame_55");
      tx_write(8'h00, w);
      check("b2b_wait_div4", 32'(w), 32'd1);
      check_frame(8'h00, "frame_00");

      for (int it = 0; it < 6; it++) begin
         div_write(4'b1111, 32'($urandom_range(0, 6)));
         check("rand_div", reg_div_do, model_div);
         b0 = 8'($urandom);
         b1 = 8'($urandom);
         tx_write(b0, w);
         check("rand_dummy_wait", 32'(w), 32'(DUMMY_BITS * bit_period() + 1));
         check_frame(b0, $sformatf("rand%0d_a", it));
         tx_write(b1, w);
         check("rand_b2b_wait", 32'(w), 32'd1);
         check_frame(b1, $sformatf("rand%0d_b", it));
      end

      div_write(4'b1111, 32'h0000_0100);
      div_write(4'b0001, 32'h0000_00AA);
      check("div_lane0", reg_div_do, 32'h0000_01AA);
      for (int it = 0; it < 4; it++) begin
         div_write(4'($urandom), $urandom);
         check("div_lane_rand", reg_div_do, model_div);
      end

      div_write(4'b1111, 32'd4);
      tx_write(8'h00, w);
      repeat (6) @(negedge clk);
      check("abort_pre_low", 32'(ser_tx), 32'd0);
      div_write(4'b1111, 32'd3);
      check("abort_ser_tx_high", 32'(ser_tx), 32'd1);
      tx_write(8'hC3, w);
      check("abort_dummy_wait", 32'(w), 32'(DUMMY_BITS * 3 + 1));
      check_frame(8'hC3, "frame_after_abort");

      div_write(4'b1111, 32'd8);
      repeat (4) @(negedge clk);
      rx_send(8'hA3, 1'b1);
      check("rx_a3", reg_dat_do, exp_dat_do());
      rx_ack();
      ser_rx = 1'b0;
      repeat (2) @(negedge clk);
      ser_rx = 1'b1;
      repeat (24) @(negedge clk);
      check("rx_glitch", reg_dat_do, exp_dat_do());
      rx_send(8'h3C, 1'b0);
      check("rx_framing_err", reg_dat_do, exp_dat_do());
      for (int it = 0; it < 8; it++) begin
         rx_send(8'($urandom), ($urandom_range(0, 3) != 0));
         check("rx_rand", reg_dat_do, exp_dat_do());
         if ($urandom_range(0, 2) == 0) rx_ack();
      end

      div_write(4'b1111, 32'd4);
      tx_write(8'h00, w);
      repeat (10) @(negedge clk);
      check("midframe_low", 32'(ser_tx), 32'd0);
      resetn = 1'b0;
      #1;
      model_div   = DEF_DIV;
      model_valid = 1'b0;
      check("reset_mid_ser_tx", 32'(ser_tx), 32'd1);
      check("reset_mid_div", reg_div_do, model_div);
      check("reset_mid_dat_do", reg_dat_do, exp_dat_do());
      @(negedge clk);
      resetn = 1'b1;
      tx_write(8'h6E, w);
      check("dummy_wait_rereset", 32'(w), 32'(DUMMY_BITS * bit_period() + 1));
      check_frame(8'h6E, "frame_rereset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
